// File: rtl/swm_tx_arbiter.sv
// ---------------------------------------------------------------------------------------------
// swm_tx_arbiter
//
// Shares one Avalon-ST TX link (toward the SL3 TX adapter) between two Avalon-ST sink ports
// at packet granularity. An idle cycle arbitrates between ports presenting a start-of-packet.
// The winner then owns the link until its end-of-packet beat transfers. While a port owns the
// link, its beats are passed through combinationally. When both ports request together, the
// port that did not win last time is granted, which gives strict alternation.
//
// Beats that arrive in IDLE without startofpacket ("headless") are accepted and dropped. They
// also set a sticky sop_err flag that only reset clears.
//
// Optional feature: define SWM_TX_ARBITER_PKTCNT_EN to add per-port completed-packet counters
// (pkt_cnt0 / pkt_cnt1, PKT_CNT_W bits, wrapping).
//
// Ports
//   clk_in_clk          in   sole clock, rising edge
//   reset_in_rst_n      in   synchronous active-low reset
//   s0_* / s1_*         sink ports: data[31:0], valid, startofpacket, endofpacket in; ready out
//   m_*                 source port: data[31:0], valid, startofpacket, endofpacket out; ready in
//   grant[1:0]          one-hot current owner (bit n = port n), 00 when idle
//   sop_err             sticky: a headless beat was discarded
//   pkt_cnt0/pkt_cnt1   (SWM_TX_ARBITER_PKTCNT_EN only) eop transfers per port, wrapping
// ---------------------------------------------------------------------------------------------
module swm_tx_arbiter #(
  parameter int unsigned PKT_CNT_W = 16
) (
  input  logic                 clk_in_clk,
  input  logic                 reset_in_rst_n,

  input  logic [31:0]          s0_data,
  input  logic                 s0_valid,
  input  logic                 s0_startofpacket,
  input  logic                 s0_endofpacket,
  output logic                 s0_ready,

  input  logic [31:0]          s1_data,
  input  logic                 s1_valid,
  input  logic                 s1_startofpacket,
  input  logic                 s1_endofpacket,
  output logic                 s1_ready,

  output logic [31:0]          m_data,
  output logic                 m_valid,
  output logic                 m_startofpacket,
  output logic                 m_endofpacket,
  input  logic                 m_ready,

  output logic [1:0]           grant,
`ifdef SWM_TX_ARBITER_PKTCNT_EN
  output logic [PKT_CNT_W-1:0] pkt_cnt0,
  output logic [PKT_CNT_W-1:0] pkt_cnt1,
`endif
  output logic                 sop_err
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } state_e;

  state_e state_q;
  logic   last_winner_q;  // port that most recently completed a packet
  logic   sop_err_q;

  // Request decode: a start-of-packet beat is a candidate; any other valid beat in IDLE
  // has no owner to go to and is dropped.
  logic cand0, cand1;
  logic head0, head1;
  logic xfer0, xfer1;
  logic eop_done0, eop_done1;

  assign cand0 = s0_valid & s0_startofpacket;
  assign cand1 = s1_valid & s1_startofpacket;
  assign head0 = s0_valid & ~s0_startofpacket;
  assign head1 = s1_valid & ~s1_startofpacket;

  assign xfer0     = (state_q == StOwn0) & s0_valid & m_ready;
  assign xfer1     = (state_q == StOwn1) & s1_valid & m_ready;
  assign eop_done0 = xfer0 & s0_endofpacket;
  assign eop_done1 = xfer1 & s1_endofpacket;

  // Datapath and handshakes. The owner's beat is forwarded unchanged, including any
  // startofpacket that appears mid-packet.
  always_comb begin
    m_data          = 32'h0;
    m_valid         = 1'b0;
    m_startofpacket = 1'b0;
    m_endofpacket   = 1'b0;
    s0_ready        = 1'b0;
    s1_ready        = 1'b0;
    grant           = 2'b00;
    unique case (state_q)
      StIdle: begin
        // Candidates are held off (ready=0) for the one arbitration cycle; headless
        // beats are swallowed.
        s0_ready = head0;
        s1_ready = head1;
      end
      StOwn0: begin
        m_data          = s0_data;
        m_valid         = s0_valid;
        m_startofpacket = s0_startofpacket;
        m_endofpacket   = s0_endofpacket;
        s0_ready        = m_ready;
        grant           = 2'b01;
      end
      StOwn1: begin
        m_data          = s1_data;
        m_valid         = s1_valid;
        m_startofpacket = s1_startofpacket;
        m_endofpacket   = s1_endofpacket;
        s1_ready        = m_ready;
        grant           = 2'b10;
      end
      default: begin
      end
    endcase
  end

  assign sop_err = sop_err_q;

  // Arbitration FSM. last_winner resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk_in_clk) begin
    if (!reset_in_rst_n) begin
      state_q       <= StIdle;
      last_winner_q <= 1'b1;
      sop_err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (head0 || head1) begin
            sop_err_q <= 1'b1;
          end
          if (cand0 && (!cand1 || last_winner_q)) begin
            state_q <= StOwn0;
          end else if (cand1) begin
            state_q <= StOwn1;
          end
        end
        StOwn0: begin
          if (eop_done0) begin
            state_q       <= StIdle;
            last_winner_q <= 1'b0;
          end
        end
        StOwn1: begin
          if (eop_done1) begin
            state_q       <= StIdle;
            last_winner_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SWM_TX_ARBITER_PKTCNT_EN
  logic [PKT_CNT_W-1:0] pkt_cnt0_q, pkt_cnt1_q;

  // Counts completed packets per port; natural binary wrap from all-ones to zero.
  always_ff @(posedge clk_in_clk) begin
    if (!reset_in_rst_n) begin
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      if (eop_done0) begin
        pkt_cnt0_q <= pkt_cnt0_q + PKT_CNT_W'(1);
      end
      if (eop_done1) begin
        pkt_cnt1_q <= pkt_cnt1_q + PKT_CNT_W'(1);
      end
    end
  end

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;
`endif

endmodule

// File: tb/tb_swm_tx_arbiter.sv
// ---------------------------------------------------------------------------------------------
// tb_swm_tx_arbiter
//
// Directed scenarios followed by a randomized run. Each sink port is driven from a queue of
// beats. A packet-level reference model tracks the link owner, the alternation rule, the
// sticky error flag and the optional per-port packet counts. Per-port expected-beat queues
// act as a scoreboard for everything that leaves on the source port.
// ---------------------------------------------------------------------------------------------
module tb_swm_tx_arbiter;

  localparam int CW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s0_data, s1_data, m_data;
  logic        s0_valid, s0_startofpacket, s0_endofpacket, s0_ready;
  logic        s1_valid, s1_startofpacket, s1_endofpacket, s1_ready;
  logic        m_valid, m_startofpacket, m_endofpacket, m_ready;
  logic [1:0]  grant;
  logic        sop_err;
`ifdef SWM_TX_ARBITER_PKTCNT_EN
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;
`endif

  swm_tx_arbiter #(.PKT_CNT_W(CW)) dut (
    .clk_in_clk       (clk),
    .reset_in_rst_n   (rst_n),
    .s0_data          (s0_data),
    .s0_valid         (s0_valid),
    .s0_startofpacket (s0_startofpacket),
    .s0_endofpacket   (s0_endofpacket),
    .s0_ready         (s0_ready),
    .s1_data          (s1_data),
    .s1_valid         (s1_valid),
    .s1_startofpacket (s1_startofpacket),
    .s1_endofpacket   (s1_endofpacket),
    .s1_ready         (s1_ready),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_startofpacket  (m_startofpacket),
    .m_endofpacket    (m_endofpacket),
    .m_ready          (m_ready),
    .grant            (grant),
`ifdef SWM_TX_ARBITER_PKTCNT_EN
    .pkt_cnt0         (pkt_cnt0),
    .pkt_cnt1         (pkt_cnt1),
`endif
    .sop_err          (sop_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Beat encoding in the queues: {sop, eop, data}.
  logic [33:0] txq0[$], txq1[$];
  logic [33:0] exp0[$], exp1[$];
  logic        cur0 = 1'b0, cur1 = 1'b0;
  logic        gaps = 1'b0;
  logic        mr_rand = 1'b0;
  logic        mr_val = 1'b1;

  // Reference model state.
  int          owner = -1;
  logic        last_w = 1'b1;
  logic        err_m = 1'b0;
`ifdef SWM_TX_ARBITER_PKTCNT_EN
  logic [CW-1:0] cnt_m0 = '0, cnt_m1 = '0;
  logic [CW-1:0] o_cnt0;
`endif

  // Samples taken mid-cycle, used by the directed steps.
  logic [31:0] o_mdata;
  logic        o_mvalid, o_meop, o_s0r, o_s1r, o_err;
  logic [1:0]  o_grant;

  // Expected grant sequence for two back-to-back 2-beat packets on each port.
  logic [1:0]  g35 [12] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2};
  logic [31:0] d35 [12] = '{32'h0, 32'hB0, 32'hB1, 32'h0, 32'hC0, 32'hC1,
                            32'h0, 32'hB2, 32'hB3, 32'h0, 32'hC2, 32'hC3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    if (!cur0 && txq0.size() > 0) cur0 = gaps ? ($urandom_range(3) != 0) : 1'b1;
    if (!cur1 && txq1.size() > 0) cur1 = gaps ? ($urandom_range(3) != 0) : 1'b1;
    s0_valid = cur0;
    s1_valid = cur1;
    if (cur0) {s0_startofpacket, s0_endofpacket, s0_data} = txq0[0];
    else      {s0_startofpacket, s0_endofpacket, s0_data} = '0;
    if (cur1) {s1_startofpacket, s1_endofpacket, s1_data} = txq1[0];
    else      {s1_startofpacket, s1_endofpacket, s1_data} = '0;
    m_ready = mr_rand ? ($urandom_range(3) != 0) : mr_val;
  endtask

  task automatic push_pkt(input int port, input int len, input logic [31:0] base, input bit rnd);
    logic [33:0] b;
    for (int i = 0; i < len; i++) begin
      b = {(i == 0), (i == len - 1), rnd ? 32'($urandom) : base + 32'(i)};
      if (port == 0) begin txq0.push_back(b); exp0.push_back(b); end
      else           begin txq1.push_back(b); exp1.push_back(b); end
    end
  endtask

  // One clock cycle: sample and check at the falling edge, advance the model, then after
  // the rising edge retire accepted beats and drive the next inputs.
  task automatic tick();
    logic        hs0, hs1, hsm, c0, c1;
    logic [33:0] obs, head;
    logic [1:0]  eg;
    @(negedge clk);
    o_mdata = m_data; o_mvalid = m_valid; o_meop = m_endofpacket;
    o_s0r = s0_ready; o_s1r = s1_ready; o_err = sop_err; o_grant = grant;
`ifdef SWM_TX_ARBITER_PKTCNT_EN
    o_cnt0 = pkt_cnt0;
`endif
    hs0 = s0_valid & s0_ready;
    hs1 = s1_valid & s1_ready;
    hsm = m_valid & m_ready;
    if (rst_n) begin
      eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
      chk("grant", 64'(grant), 64'(eg));
      chk("m_valid", 64'(m_valid),
          64'((owner == 0) ? s0_valid : (owner == 1) ? s1_valid : 1'b0));
      chk("s0_ready", 64'(s0_ready),
          64'((owner == 0) ? m_ready : (owner == 1) ? 1'b0 : (s0_valid & ~s0_startofpacket)));
      chk("s1_ready", 64'(s1_ready),
          64'((owner == 1) ? m_ready : (owner == 0) ? 1'b0 : (s1_valid & ~s1_startofpacket)));
      chk("sop_err", 64'(sop_err), 64'(err_m));
`ifdef SWM_TX_ARBITER_PKTCNT_EN
      chk("pkt_cnt0", 64'(pkt_cnt0), 64'(cnt_m0));
      chk("pkt_cnt1", 64'(pkt_cnt1), 64'(cnt_m1));
`endif
      if (hsm) begin
        obs = {m_startofpacket, m_endofpacket, m_data};
        head = 'x;
        if (owner == 0 && exp0.size() > 0) head = exp0.pop_front();
        if (owner == 1 && exp1.size() > 0) head = exp1.pop_front();
        chk("sb_beat", 64'(obs), 64'(head));
      end
      if (owner < 0) begin
        if ((s0_valid && !s0_startofpacket) || (s1_valid && !s1_startofpacket)) err_m = 1'b1;
        c0 = s0_valid & s0_startofpacket;
        c1 = s1_valid & s1_startofpacket;
        if (c0 && c1) owner = last_w ? 0 : 1;
        else if (c0)  owner = 0;
        else if (c1)  owner = 1;
      end else if (owner == 0) begin
        if (s0_valid && m_ready && s0_endofpacket) begin
          owner = -1; last_w = 1'b0;
`ifdef SWM_TX_ARBITER_PKTCNT_EN
          cnt_m0 = cnt_m0 + 1'b1;
`endif
        end
      end else begin
        if (s1_valid && m_ready && s1_endofpacket) begin
          owner = -1; last_w = 1'b1;
`ifdef SWM_TX_ARBITER_PKTCNT_EN
          cnt_m1 = cnt_m1 + 1'b1;
`endif
        end
      end
    end else begin
      owner = -1; last_w = 1'b1; err_m = 1'b0;
`ifdef SWM_TX_ARBITER_PKTCNT_EN
      cnt_m0 = '0; cnt_m1 = '0;
`endif
    end
    @(posedge clk);
    #1;
    if (hs0) begin txq0.delete(0); cur0 = 1'b0; end
    if (hs1) begin txq1.delete(0); cur1 = 1'b0; end
    drive_inputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    txq0.delete(); txq1.delete(); exp0.delete(); exp1.delete();
    cur0 = 1'b0; cur1 = 1'b0;
    drive_inputs();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    drive_inputs();
    do_reset();

    // Reset state with quiet inputs.
    tick();
    chk("rst_grant", 64'(o_grant), 64'(2'b00));
    chk("rst_m_valid", 64'(o_mvalid), 64'(1'b0));
    chk("rst_s0_ready", 64'(o_s0r), 64'(1'b0));
    chk("rst_s1_ready", 64'(o_s1r), 64'(1'b0));
    chk("rst_sop_err", 64'(o_err), 64'(1'b0));

    // Port 0 alone, 4-beat packet A0..A3.
    push_pkt(0, 4, 32'hA0, 0);
    drive_inputs();
    tick();
    chk("a_idle_grant", 64'(o_grant), 64'(2'b00));
    chk("a_idle_s0_ready", 64'(o_s0r), 64'(1'b0));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("a_data", 64'(o_mdata), 64'(32'hA0 + 32'(i)));
      chk("a_grant", 64'(o_grant), 64'(2'b01));
      chk("a_eop", 64'(o_meop), 64'(i == 3));
    end
    tick();
    chk("a_back_idle", 64'(o_mvalid), 64'(1'b0));

    // Simultaneous requests right after reset: strict alternation, one bubble each.
    do_reset();
    push_pkt(0, 2, 32'hB0, 0); push_pkt(0, 2, 32'hB2, 0);
    push_pkt(1, 2, 32'hC0, 0); push_pkt(1, 2, 32'hC2, 0);
    drive_inputs();
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("alt_grant", 64'(o_grant), 64'(g35[k]));
      if (g35[k] != 2'd0) chk("alt_data", 64'(o_mdata), 64'(d35[k]));
    end

    // Single-beat packets on port 1 every cycle: one per two cycles.
    do_reset();
    for (int i = 0; i < 6; i++) push_pkt(1, 1, 32'hD0 + 32'(i), 0);
    drive_inputs();
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("single_grant", 64'(o_grant), 64'((k % 2) ? 2'b10 : 2'b00));
      chk("single_valid", 64'(o_mvalid), 64'(k % 2));
    end

    // m_ready low for 3 cycles mid-packet.
    do_reset();
    push_pkt(0, 4, 32'hE0, 0);
    drive_inputs();
    tick();
    tick();
    chk("stall_first", 64'(o_mdata), 64'(32'hE0));
    mr_val = 1'b0; m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_valid", 64'(o_mvalid), 64'(1'b1));
      chk("stall_data", 64'(o_mdata), 64'(32'hE1));
      chk("stall_s0_ready", 64'(o_s0r), 64'(1'b0));
    end
    mr_val = 1'b1; m_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("stall_resume", 64'(o_mdata), 64'(32'hE0 + 32'(i)));
    end
    tick();

    // Headless beat on port 1 in IDLE.
    do_reset();
    txq1.push_back({2'b00, 32'h55});
    drive_inputs();
    tick();
    chk("hl_s1_ready", 64'(o_s1r), 64'(1'b1));
    chk("hl_m_valid", 64'(o_mvalid), 64'(1'b0));
    chk("hl_err_same", 64'(o_err), 64'(1'b0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hl_err_sticky", 64'(o_err), 64'(1'b1));
    end
    do_reset();
    tick();
    chk("hl_err_cleared", 64'(o_err), 64'(1'b0));

    // Reset on beat 2 of 4, then a clean resend.
    push_pkt(0, 4, 32'hF0, 0);
    drive_inputs();
    tick(); tick(); tick();
    do_reset();
    push_pkt(0, 4, 32'hF0, 0);
    drive_inputs();
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("resend_data", 64'(o_mdata), 64'(32'hF0 + 32'(i)));
    end
    tick();
`ifdef SWM_TX_ARBITER_PKTCNT_EN
    chk("cnt_one", 64'(o_cnt0), 64'(2'd1));
    for (int i = 0; i < 3; i++) push_pkt(0, 1, 32'h70 + 32'(i), 0);
    drive_inputs();
    for (int k = 0; k < 7; k++) tick();
    chk("cnt_wrap", 64'(o_cnt0), 64'(2'd0));
`endif

    // Randomized traffic with gaps and random backpressure.
    do_reset();
    gaps = 1'b1; mr_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (txq0.size() == 0 && $urandom_range(3) == 0) push_pkt(0, $urandom_range(4, 1), 0, 1);
      if (txq1.size() == 0 && $urandom_range(3) == 0) push_pkt(1, $urandom_range(4, 1), 0, 1);
      drive_inputs();
      tick();
    end
    n = 0;
    while ((txq0.size() + txq1.size() + exp0.size() + exp1.size()) != 0 && n < 1000) begin
      tick();
      n++;
    end
    chk("drain_tx", 64'(txq0.size() + txq1.size()), 64'(0));
    chk("drain_exp0", 64'(exp0.size()), 64'(0));
    chk("drain_exp1", 64'(exp1.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/swm_tx_arbiter.md
SWM_TX_ARBITER -- requirements
Module: swm_tx_arbiter

Interface
REQ-001 SHALL have parameter: PKT_CNT_W, default 16, width of the per-port packet counters.
REQ-002 SHALL have port: clk_in_clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset_in_rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: s0_data / s1_data  input  32  Avalon-ST sink data, ports 0 and 1.
REQ-005 SHALL have ports: s0_valid, s0_startofpacket, s0_endofpacket (and the s1_ equivalents)  input  1 each  sink qualifiers.
REQ-006 SHALL have ports: s0_ready / s1_ready  output  1  sink backpressure.
REQ-007 SHALL have ports: m_data  output  32; m_valid, m_startofpacket, m_endofpacket  output  1 each; Avalon-ST source toward the SL3 TX adapter.
REQ-008 SHALL have port: m_ready  input  1  source backpressure.
REQ-009 SHALL have port: grant  output  2  one-hot current owner, 00 when idle.
REQ-010 SHALL have port: sop_err  output  1  sticky flag: a headless beat was discarded.

Function
REQ-011 SHALL share the single TX link between ports 0 and 1 at packet granularity; a granted packet is never interleaved with another.
REQ-012 SHALL implement the states IDLE, OWN0 and OWN1.
REQ-013 IDLE behaviour: m_valid=0, grant=00.
REQ-014 IDLE, port n with valid&startofpacket is a candidate and its ready=0.
REQ-015 IDLE, one candidate: SHALL go to OWNn next cycle.
REQ-016 IDLE, both candidates: SHALL grant the port not equal to last_winner; last_winner resets to 1, so port 0 wins first.
REQ-017 OWNn: m_data, m_valid, m_startofpacket and m_endofpacket SHALL equal port n's inputs combinationally.
REQ-018 OWNn: sn_ready=m_ready and the other port's ready=0; grant is one-hot n.
REQ-019 OWNn: a beat transfers when sn_valid&m_ready.
REQ-020 OWNn: a transfer with sn_endofpacket=1 SHALL return to IDLE next cycle and set last_winner=n.
REQ-021 Arbitration latency SHALL be exactly 1 cycle (IDLE to OWNn); every packet incurs exactly one idle bubble.
REQ-022 A single-beat packet (sop=eop=1) SHALL complete in OWNn in one transfer cycle.
REQ-023 IDLE, port n with valid=1 and startofpacket=0: sn_ready=1 and the beat is discarded.
REQ-024 A discarded beat SHALL set sop_err, held until reset, and SHALL NOT be a candidate.
REQ-025 If both ports present headless beats, both SHALL be discarded in the same cycle.
REQ-026 OWNn with sn_valid=0 SHALL hold state indefinitely; there is no timeout.
REQ-027 m_ready low SHALL stall without losing or duplicating beats.
REQ-028 A startofpacket inside an owned packet SHALL be forwarded unchanged; no mid-packet re-arbitration.

Reset
REQ-029 reset_in_rst_n=0 sampled at an edge SHALL force, next cycle: state=IDLE, last_winner=1, sop_err=0, grant=00, m_valid=0, s0_ready=s1_ready=0, and counters (if present)=0.
REQ-030 Reset mid-packet SHALL abandon the packet with no eop emitted; recovery of the truncated packet is the downstream's responsibility.

Configuration
REQ-031 Macro SWM_TX_ARBITER_PKTCNT_EN defined: SHALL add outputs pkt_cnt0 and pkt_cnt1 (PKT_CNT_W each).
REQ-032 With SWM_TX_ARBITER_PKTCNT_EN defined: pkt_cntn SHALL increment by 1 on each eop transfer from port n, wrap from all-ones to 0, and update on the cycle after the transfer.
REQ-033 Macro undefined: these ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Port 0 alone sends a 4-beat packet 0xA0..0xA3, m_ready=1 -> m_data A0..A3 on cycles 1-4 after sop is asserted, eop on A3, grant=01, then IDLE.
REQ-035 Both ports assert sop in the same cycle right after reset -> port 0 packet first, then 1 idle cycle, then port 1; repeat -> strict alternation.
REQ-036 Single-beat packets on port 1 every cycle, port 0 silent -> one packet per 2 cycles, grant toggles 10/00.
REQ-037 m_ready deasserted for 3 cycles mid-packet -> m_valid and m_data held stable, s0_ready=0, no beat lost or duplicated.
REQ-038 Port 1 sends a headless beat 0x55 in IDLE -> s1_ready=1, m_valid=0, sop_err=1 from the next cycle until reset.
REQ-039 Reset asserted on beat 2 of 4, then packet resent -> full packet forwarded cleanly; with SWM_TX_ARBITER_PKTCNT_EN, pkt_cnt0=1 and PKT_CNT_W=2 wraps 3->0 on the fourth packet.
